// File: rtl/nvl2_timer.sv
// nvl2_timer: MM:SS BCD cooking timer with keypad entry.
// Keypad digits shift in from the right while the magnetron is off. While
// mag_on is high and the time is nonzero, the time counts down one second
// every TICKS_PER_SEC clocks. timer_done is a pure decode of the digits, so
// the downstream magnetron control sees 00:00 in the same cycle it appears.
module nvl2_timer #(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clearn,
  input  logic       mag_on,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done,
  output logic       tick
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);

  // Operating mode is decoded from the digits and mag_on; it is never stored.
  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_SET,
    ST_RUN
  } tmr_state_e;

  tmr_state_e state;

  logic [3:0]    min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
  logic [3:0]    min_tens_d, min_ones_d, sec_tens_d, sec_ones_d;
  logic [3:0]    dec_mt, dec_mo, dec_st, dec_so;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;
  logic          is_zero;
  logic          key_accept;

  assign is_zero    = (min_tens_q == 4'd0) && (min_ones_q == 4'd0) &&
                      (sec_tens_q == 4'd0) && (sec_ones_q == 4'd0);
  assign key_accept = !mag_on && key_valid && (key_digit <= 4'd9);

  // Decode the derived operating mode.
  always_comb begin
    if (is_zero)     state = ST_EMPTY;
    else if (mag_on) state = ST_RUN;
    else             state = ST_SET;
  end

  // One-second BCD decrement with borrow chain. Seconds tens reload 5 on a
  // borrow, so entered values 60-99 in the seconds field count as plain
  // seconds until the first minute borrow. Only used when the time is nonzero.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned; otherwise a latch is inferred.
    dec_mt = min_tens_q;
    dec_mo = min_ones_q;
    dec_st = sec_tens_q;
    dec_so = sec_ones_q;
    if (sec_ones_q != 4'd0) begin
      dec_so = sec_ones_q - 4'd1;
    end else begin
      dec_so = 4'd9;
      if (sec_tens_q != 4'd0) begin
        dec_st = sec_tens_q - 4'd1;
      end else begin
        dec_st = 4'd5;
        if (min_ones_q != 4'd0) begin
          dec_mo = min_ones_q - 4'd1;
        end else begin
          dec_mo = 4'd9;
          dec_mt = min_tens_q - 4'd1;
        end
      end
    end
  end

  // Next-state selection in priority order: clear, run, key entry, hold.
  always_comb begin
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    pre_d      = pre_q;
    tick_d     = 1'b0;
    if (!clearn) begin
      min_tens_d = 4'd0;
      min_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      sec_ones_d = 4'd0;
      pre_d      = '0;
    end else if (state == ST_RUN) begin
      if (pre_q == PRE_MAX) begin
        pre_d      = '0;
        min_tens_d = dec_mt;
        min_ones_d = dec_mo;
        sec_tens_d = dec_st;
        sec_ones_d = dec_so;
        tick_d     = 1'b1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end else if (key_accept) begin
      min_tens_d = min_ones_q;
      min_ones_d = sec_tens_q;
      sec_tens_d = sec_ones_q;
      sec_ones_d = key_digit;
      pre_d      = '0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      min_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      sec_ones_q <= 4'd0;
      pre_q      <= '0;
      tick_q     <= 1'b0;
    end else begin
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      pre_q      <= pre_d;
      tick_q     <= tick_d;
    end
  end

  assign min_tens   = min_tens_q;
  assign min_ones   = min_ones_q;
  assign sec_tens   = sec_tens_q;
  assign sec_ones   = sec_ones_q;
  assign timer_done = is_zero;
  assign tick       = tick_q;

endmodule

// File: tb/tb_nvl2_timer.sv
// Testbench for nvl2_timer with TICKS_PER_SEC=4. Expected displays are queued
// when stimulus is applied and compared when the DUT reaches them.
module tb_nvl2_timer;

  localparam int TPS = 4;

  logic       clk = 1'b0;
  logic       reset, clearn, mag_on, key_valid;
  logic [3:0] key_digit;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       timer_done, tick;
  logic [15:0] disp;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          cyc;
    logic [15:0] digits;
  } exp_t;

  exp_t sb[$];

  nvl2_timer #(.TICKS_PER_SEC(TPS)) dut (
    .clk        (clk),
    .reset      (reset),
    .clearn     (clearn),
    .mag_on     (mag_on),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .timer_done (timer_done),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  assign disp = {min_tens, min_ones, sec_tens, sec_ones};

  // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Plain seconds (< 60) to the normal MM:SS digit form.
  function automatic logic [15:0] secs_to_bcd(input int s);
    logic [15:0] r;
    r[15:12] = 4'((s / 60) / 10);
    r[11:8]  = 4'((s / 60) % 10);
    r[7:4]   = 4'((s % 60) / 10);
    r[3:0]   = 4'((s % 60) % 10);
    return r;
  endfunction

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    step();
    key_valid = 1'b0;
    key_digit = 4'd0;
  endtask

  // Clear then key in four digits with the magnetron off.
  task automatic load(input logic [15:0] v);
    mag_on = 1'b0;
    clearn = 1'b0;
    step();
    clearn = 1'b1;
    press(v[15:12]);
    press(v[11:8]);
    press(v[7:4]);
    press(v[3:0]);
  endtask

  task automatic test_reset();
    reset = 1'b1; clearn = 1'b1; mag_on = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
    step();
    step();
    checks++;
    if (disp !== 16'h0000) begin errors++; $display("FAIL reset_digits got %h want 0000", disp); end
    checks++;
    if (timer_done !== 1'b1) begin errors++; $display("FAIL reset_done got %b want 1", timer_done); end
    checks++;
    if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", tick); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_key_entry();
    logic [3:0] keys [4] = '{4'd1, 4'd3, 4'd12, 4'd0};
    logic [15:0] want [4] = '{16'h0001, 16'h0013, 16'h0013, 16'h0130};
    exp_t e;
    mag_on = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{cyc: i, digits: want[i]});
      press(keys[i]);
      e = sb.pop_front();
      checks++;
      if (disp !== e.digits) begin
        errors++; $display("FAIL key_entry[%0d] got %h want %h", e.cyc, disp, e.digits);
      end
    end
    checks++;
    if (timer_done !== 1'b0) begin errors++; $display("FAIL key_done got %b want 0", timer_done); end
  endtask

  task automatic test_full_countdown();
    exp_t e;
    int n_tick = 0;
    load(16'h0100);
    for (int k = 1; k <= 60; k++) sb.push_back('{cyc: k * TPS, digits: secs_to_bcd(60 - k)});
    mag_on = 1'b1;
    for (int c = 1; c <= 60 * TPS + 20; c++) begin
      step();
      if (tick === 1'b1) begin
        n_tick++;
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL cd_extra_tick got tick at edge %0d want none", c);
        end else begin
          e = sb.pop_front();
          if (c != e.cyc || disp !== e.digits) begin
            errors++;
            $display("FAIL cd_step got %h at edge %0d want %h at edge %0d", disp, c, e.digits, e.cyc);
          end
        end
      end
      if (c == 60 * TPS - 1) begin
        checks++;
        if (timer_done !== 1'b0) begin errors++; $display("FAIL cd_done_early got %b want 0", timer_done); end
      end
      if (c == 60 * TPS) begin
        checks++;
        if (timer_done !== 1'b1 || disp !== 16'h0000) begin
          errors++; $display("FAIL cd_done got %b/%h want 1/0000", timer_done, disp);
        end
      end
    end
    checks++;
    if (n_tick != 60 || sb.size() != 0) begin
      errors++; $display("FAIL cd_tick_count got %0d want 60", n_tick);
    end
    sb.delete();
    mag_on = 1'b0;
  endtask

  task automatic test_pause_resume();
    int stray = 0;
    load(16'h0005);
    mag_on = 1'b1;
    step();
    step();                       // prescaler now at 2
    mag_on = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tick === 1'b1 || disp !== 16'h0005) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL pause_hold got %0d bad cycles want 0", stray); end
    mag_on = 1'b1;
    step();
    checks++;
    if (tick !== 1'b0 || disp !== 16'h0005) begin
      errors++; $display("FAIL resume_early got tick=%b %h want tick=0 0005", tick, disp);
    end
    sb.push_back('{cyc: 2, digits: 16'h0004});
    step();
    if (tick === 1'b1) begin
      exp_t e = sb.pop_front();
      checks++;
      if (disp !== e.digits) begin errors++; $display("FAIL resume_dec got %h want %h", disp, e.digits); end
    end else begin
      checks++; errors++; $display("FAIL resume_tick got tick=0 want 1 at edge 2");
      sb.delete();
    end
    mag_on = 1'b0;
  endtask

  task automatic test_clear_lockout();
    int stray = 0;
    load(16'h0045);
    mag_on = 1'b1;
    for (int i = 0; i < 6; i++) step();
    clearn = 1'b0;
    step();
    clearn = 1'b1;
    checks++;
    if (disp !== 16'h0000 || timer_done !== 1'b1) begin
      errors++; $display("FAIL clear_run got %h/%b want 0000/1", disp, timer_done);
    end
    press(4'd7);
    press(4'd8);
    checks++;
    if (disp !== 16'h0000) begin errors++; $display("FAIL key_lockout got %h want 0000", disp); end
    for (int i = 0; i < 8; i++) begin
      step();
      if (tick === 1'b1 || timer_done !== 1'b1) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL empty_run got %0d bad cycles want 0", stray); end
    // Synchronous reset during a run behaves like clear.
    load(16'h0030);
    mag_on = 1'b1;
    for (int i = 0; i < 6; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (disp !== 16'h0000 || timer_done !== 1'b1 || tick !== 1'b0) begin
      errors++; $display("FAIL reset_run got %h/%b/%b want 0000/1/0", disp, timer_done, tick);
    end
    mag_on = 1'b0;
  endtask

  task automatic borrow_case(input logic [15:0] start, input logic [15:0] want);
    exp_t e;
    int got = 0;
    load(start);
    sb.push_back('{cyc: TPS, digits: want});
    mag_on = 1'b1;
    for (int c = 1; c <= TPS + 2 && got == 0; c++) begin
      step();
      if (tick === 1'b1) begin
        got = 1;
        e = sb.pop_front();
        checks++;
        if (disp !== e.digits || c != e.cyc) begin
          errors++; $display("FAIL borrow_%h got %h at edge %0d want %h at edge %0d", start, disp, c, e.digits, e.cyc);
        end
      end
    end
    if (got == 0) begin
      checks++; errors++; $display("FAIL borrow_%h got no tick want tick at edge %0d", start, TPS);
      sb.delete();
    end
    mag_on = 1'b0;
  endtask

  task automatic test_borrow_chain();
    borrow_case(16'h0099, 16'h0098);
    borrow_case(16'h1000, 16'h0959);
    borrow_case(16'h0100, 16'h0059);
    borrow_case(16'h9999, 16'h9998);
    borrow_case(16'h0160, 16'h0159);
  endtask

  initial begin
    test_reset();
    test_key_entry();
    test_full_countdown();
    test_pause_resume();
    test_clear_lockout();
    test_borrow_chain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
